// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern sequencer: FSM states,
// DIP-switch mode encodings and the polarity-aware LED drive function.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SCAN   = 3'd2,
        BLINK  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SCAN  = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_COMBO = 2'b11;

    // Widest LED bank the drive helper supports; callers size-cast in and out.
    localparam int LED_MAX = 32;

    function automatic logic [LED_MAX-1:0] led_drive(input logic [LED_MAX-1:0] lit_vector,
                                                     input logic               active_low);
        logic [LED_MAX-1:0] drive;
        if (active_low) begin
            drive = ~lit_vector;
        end else begin
            drive = lit_vector;
        end
        return drive;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick generator with two selectable periods and a synchronous clear.
// o_tick is high in the cycle the count sits at the selected period minus one.
module tick_prescaler #(
    parameter int PERIOD_0 = 1,
    parameter int PERIOD_1 = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    input  logic i_sel,
    output logic o_tick
);

    localparam int P_MAX = (PERIOD_0 > PERIOD_1) ? PERIOD_0 : PERIOD_1;
    localparam int W     = $clog2(P_MAX + 1);
    localparam logic [W-1:0] LAST_0 = W'(PERIOD_0 - 1);
    localparam logic [W-1:0] LAST_1 = W'(PERIOD_1 - 1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_last;
    logic         w_at_last;

    // Select the terminal count for the active period.
    always_comb begin
        if (i_sel) begin
            w_last = LAST_1;
        end else begin
            w_last = LAST_0;
        end
    end

    assign w_at_last = (r_count == w_last);
    assign o_tick    = i_en && !i_clear && w_at_last;

    // Count 0..P-1 while enabled, wrapping on the tick.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= {W{1'b0}};
        end else if (i_en) begin
            if (w_at_last) begin
                r_count <= {W{1'b0}};
            end else begin
                r_count <= r_count + W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: bounce scan, all-LED blink and scan-then-blink combo,
// selected by synchronised DIP switches, with loop/play-once and busy/done status.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int N_LED        = 4,
    parameter int STEP_CYCLES  = 5000000,
    parameter int BLINK_CYCLES = 8000000,
    parameter int N_BLINK      = 3,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             repeat_en,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int SWEEP  = (N_LED == 1) ? 1 : 2 * N_LED - 2;
    localparam int SW     = (SWEEP > 1) ? $clog2(SWEEP) : 1;
    localparam int PHASES = 2 * N_BLINK;
    localparam int PW     = $clog2(PHASES);
    localparam logic [SW-1:0]    SWEEP_LAST = SW'(SWEEP - 1);
    localparam logic [PW-1:0]    PHASE_LAST = PW'(PHASES - 1);
    localparam logic             AL         = (ACTIVE_LOW != 0);
    localparam logic [N_LED-1:0] LIT_NONE   = {N_LED{1'b0}};
    localparam logic [N_LED-1:0] LIT_ALL    = {N_LED{1'b1}};

    state_t            r_state;
    logic [1:0]        r_mode_meta;
    logic [1:0]        r_mode_sync;
    logic [1:0]        r_mode_act;
    logic              r_hold;
    logic [SW-1:0]     r_step;
    logic [PW-1:0]     r_phase;
    logic [N_LED-1:0]  r_led;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_abort;
    logic [N_LED-1:0]  w_led_dark;
    logic [N_LED-1:0]  w_led_all;
    logic [N_LED-1:0]  w_led_first;
    logic [N_LED-1:0]  w_led_next;

    // Sweep step k lights index k on the way up, then folds back down without repeating the ends.
    function automatic logic [N_LED-1:0] scan_lit(input logic [SW-1:0] step);
        int s;
        int p;
        s = int'(step);
        if (s < N_LED) begin
            p = s;
        end else begin
            p = 2 * N_LED - 2 - s;
        end
        return N_LED'(1'b1) << p;
    endfunction

    tick_prescaler #(
        .PERIOD_0 (STEP_CYCLES),
        .PERIOD_1 (BLINK_CYCLES)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_en    ((r_state == SCAN) || (r_state == BLINK)),
        .i_clear (r_state == START),
        .i_sel   (r_state == BLINK),
        .o_tick  (w_tick)
    );

    assign w_abort = (r_mode_sync != r_mode_act);

    // Polarity-correct pin values for each lit pattern the FSM can load.
    always_comb begin
        w_led_dark  = N_LED'(led_drive(LED_MAX'(LIT_NONE), AL));
        w_led_all   = N_LED'(led_drive(LED_MAX'(LIT_ALL), AL));
        w_led_first = N_LED'(led_drive(LED_MAX'(scan_lit({SW{1'b0}})), AL));
        w_led_next  = N_LED'(led_drive(LED_MAX'(scan_lit(r_step + SW'(1))), AL));
    end

    // Two-flop synchroniser for the asynchronous DIP switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_meta <= MODE_OFF;
            r_mode_sync <= MODE_OFF;
        end else begin
            r_mode_meta <= mode;
            r_mode_sync <= r_mode_meta;
        end
    end

    // Pattern FSM with registered LED, busy and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode_act <= MODE_OFF;
            r_hold     <= 1'b0;
            r_step     <= {SW{1'b0}};
            r_phase    <= {PW{1'b0}};
            r_led      <= w_led_dark;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A finished play-once pattern stays dark until the switches return to off.
            if (r_mode_sync == MODE_OFF) begin
                r_hold <= 1'b0;
            end else if (r_state == FINISH) begin
                r_hold <= 1'b1;
            end else begin
                r_hold <= r_hold;
            end

            case (r_state)
                IDLE: begin
                    r_led <= w_led_dark;
                    if ((r_mode_sync != MODE_OFF) && !r_hold) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                START: begin
                    r_step     <= {SW{1'b0}};
                    r_phase    <= {PW{1'b0}};
                    r_mode_act <= r_mode_sync;
                    if (r_mode_sync == MODE_OFF) begin
                        r_state <= IDLE;
                        r_led   <= w_led_dark;
                        r_busy  <= 1'b0;
                    end else if (r_mode_sync == MODE_BLINK) begin
                        r_state <= BLINK;
                        r_led   <= w_led_all;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= SCAN;
                        r_led   <= w_led_first;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_abort) begin
                        r_state <= (r_mode_sync == MODE_OFF) ? IDLE : START;
                        r_led   <= w_led_dark;
                        r_busy  <= (r_mode_sync != MODE_OFF);
                    end else if (w_tick) begin
                        if (r_step != SWEEP_LAST) begin
                            r_step <= r_step + SW'(1);
                            r_led  <= w_led_next;
                        end else if (r_mode_act == MODE_COMBO) begin
                            r_state <= BLINK;
                            r_phase <= {PW{1'b0}};
                            r_led   <= w_led_all;
                        end else if (repeat_en) begin
                            r_step <= {SW{1'b0}};
                            r_led  <= w_led_first;
                        end else begin
                            r_state <= FINISH;
                            r_led   <= w_led_dark;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_led <= r_led;
                    end
                end
                BLINK: begin
                    if (w_abort) begin
                        r_state <= (r_mode_sync == MODE_OFF) ? IDLE : START;
                        r_led   <= w_led_dark;
                        r_busy  <= (r_mode_sync != MODE_OFF);
                    end else if (w_tick) begin
                        if (r_phase != PHASE_LAST) begin
                            r_phase <= r_phase + PW'(1);
                            // Even half-phases are lit, so the next one is lit when this one is odd.
                            r_led   <= r_phase[0] ? w_led_all : w_led_dark;
                        end else if (!repeat_en) begin
                            r_state <= FINISH;
                            r_led   <= w_led_dark;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_mode_act == MODE_COMBO) begin
                            r_state <= START;
                            r_led   <= w_led_dark;
                        end else begin
                            r_phase <= {PW{1'b0}};
                            r_led   <= w_led_all;
                        end
                    end else begin
                        r_led <= r_led;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_led   <= w_led_dark;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_led   <= w_led_dark;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = r_led;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Parametrised LED pattern sequencer driving N_LED board LEDs from a 2-bit mode select (DIP switches).
- Generates three patterns: bounce scan, all-LED blink, and scan-then-blink combo. Each pattern is timed by an internal prescaler.
- Supports loop or play-once operation, with a busy flag and a done pulse.
- Sits between the board DIP inputs and the LED pins. One instance per LED bank.

Parameters:
- N_LED, 4, number of LEDs (>=1).
- STEP_CYCLES, 5000000, clk cycles per scan position (>=1).
- BLINK_CYCLES, 8000000, clk cycles per blink half-phase (>=1).
- N_BLINK, 3, on/off pairs per blink pattern (>=1).
- ACTIVE_LOW, 1, 1: lit LED driven 0; 0: lit LED driven 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- mode, in, 2: 00 off, 01 scan, 10 blink, 11 combo.
- repeat_en, in, 1: 1 loop pattern forever; 0 play once then hold dark.
- led, out, N_LED: LED drive, polarity per ACTIVE_LOW.
- busy, out, 1: high while a pattern is running.
- done, out, 1: one-cycle pulse when a play-once pattern completes.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, ports clk and rst.
- While rst is high, the state machine goes to IDLE and the prescaler to 0.
- Reset outputs: led all-dark (all 1s if ACTIVE_LOW, else all 0s), busy=0, done=0.
- All outputs are registered. "Lit" means the polarity-correct level.
- Prescaler (tick generator):
  - Counts 0..P-1, with P=STEP_CYCLES in SCAN and P=BLINK_CYCLES in BLINK.
  - A tick occurs in the cycle the count equals P-1; the count then returns to 0.
  - Width is $clog2 of max(STEP_CYCLES, BLINK_CYCLES)+1.
- State IDLE:
  - led dark, busy=0.
  - Enter START when mode!=00 and no finished-hold is latched.
- State START (1 cycle):
  - Clear the prescaler and pos/phase indices.
  - Go to SCAN if mode is 01 or 11; go to BLINK if mode is 10.
- State SCAN:
  - Exactly one LED is lit, at index pos; busy=1.
  - Position sequence: 0,1,..,N_LED-1,N_LED-2,..,1, i.e. 2*N_LED-2 positions per sweep, one per tick.
  - N_LED=1: a sweep is one position (index 0) lasting STEP_CYCLES.
  - Sweep end (tick at the last position):
    - mode 11: go to BLINK.
    - mode 01 with repeat_en=1: wrap to pos 0.
    - mode 01 with repeat_en=0: go to FINISH.
- State BLINK:
  - 2*N_BLINK half-phases alternate all-lit, all-dark, all-lit, ..., starting all-lit; busy=1.
  - After the last half-phase:
    - repeat_en=1: mode 10 restarts BLINK; mode 11 goes to START (scan again).
    - repeat_en=0: go to FINISH.
- State FINISH (1 cycle):
  - done=1, led dark, busy=0.
  - Set the hold latch, then go to IDLE.
- Hold latch: cleared when mode==00 or on rst. This stops a play-once pattern from restarting until the switches return to off.
- Mode change:
  - mode is sampled through a 2-FF synchroniser, adding 2 cycles of latency.
  - Any change of the synchronised mode while in SCAN/BLINK aborts the pattern immediately. The next cycle is START (new mode!=00) or IDLE (new mode==00). No done pulse is issued.
- repeat_en is sampled only at pattern end. Changing it mid-pattern does not abort.
- Latency: the first lit LED appears 1 cycle after START, i.e. 4 cycles after the mode edge at the pin.
- Simultaneous events: rst dominates everything. A mode change dominates a tick in the same cycle.

Decomposition:
- Shared package led_pkg holds:
  - the state enum (IDLE, START, SCAN, BLINK, FINISH);
  - mode encodings MODE_OFF, MODE_SCAN, MODE_BLINK, MODE_COMBO;
  - a function led_drive(lit_vector, ACTIVE_LOW).
- One natural sub-module: tick_prescaler, a parametrised counter with period select, clear, and tick output, reusable by other board blocks.

Test Plan (N_LED=4, STEP_CYCLES=3, BLINK_CYCLES=2, N_BLINK=2, ACTIVE_LOW=1):
- rst high 3 cycles, mode=01 → led=1111, busy=0, done=0 throughout reset.
- mode=01, repeat_en=1 → led sequence 1110,1101,1011,0111,1011,1101,1110,... with each value held exactly 3 cycles; busy=1.
- mode=10, repeat_en=0 → led 0000,1111,0000,1111, each held 2 cycles, then a single done pulse, led=1111, busy=0. Stays idle until mode goes 00 then 10 again.
- mode=11, repeat_en=1 → 6 scan positions (18 cycles), then 4 blink half-phases (8 cycles), then a scan restart at 1110.
- mode 01→10 in the middle of position 2 → 2 cycles later START, then led=0000 (blink). No done pulse.
- mode=01 with rst asserted at position 3 → next cycle led=1111, busy=0. After rst is released, the scan restarts at 1110.
